// File: rtl/operand_select_sequencer.sv
// Operand-select sequencer: turns one command at a time into operand-mux selection codes,
// with I/O status polling ahead of data fetch. Optional poll timeout via OPSEQ_TIMEOUT_EN.
module operand_select_sequencer #(
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             status_ready,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             done,
  output logic             err_illegal,
  output logic             timeout_err,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, POLL, FETCH, FIN} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op, op_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             to_nxt;

  logic [SEL_W-1:0] sel_nxt;
  logic             sel_valid_nxt, done_nxt, err_illegal_nxt, timeout_err_nxt;
  logic             busy_nxt, cmd_ready_nxt;

  // The poll counter must be able to reach the timeout without saturating first.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << CNT_W) - 1) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYC");
  end

  function automatic logic [SEL_W-1:0] issue_code(input logic [2:0] o);
    case (o)
      3'd0:    issue_code = SEL_W'(0);
      3'd1:    issue_code = SEL_W'(1);
      3'd2:    issue_code = SEL_W'(2);
      default: issue_code = SEL_W'(4);
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    cnt_nxt   = cnt;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_nxt  = cmd_op;
          cnt_nxt = '0;
          case (cmd_op)
            3'd0, 3'd1, 3'd2, 3'd4: state_nxt = ISSUE;
            3'd3:                   state_nxt = POLL;
            default:                state_nxt = FIN;
          endcase
        end
      end
      POLL: begin
        if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
        // Ready on the final allowed beat still wins over the timeout.
        if (status_ready) begin
          state_nxt = FETCH;
        end
`ifdef OPSEQ_TIMEOUT_EN
        else if (cnt_nxt >= CNT_W'(TIMEOUT_CYC)) begin
          state_nxt = FIN;
          to_nxt    = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    sel_nxt         = '0;
    sel_valid_nxt   = 1'b0;
    done_nxt        = 1'b0;
    err_illegal_nxt = 1'b0;
    timeout_err_nxt = 1'b0;
    cmd_ready_nxt   = (state_nxt == IDLE);
    busy_nxt        = (state_nxt != IDLE);
    case (state_nxt)
      ISSUE: begin
        sel_nxt       = issue_code(op_nxt);
        sel_valid_nxt = 1'b1;
        done_nxt      = 1'b1;
      end
      POLL: begin
        sel_nxt       = SEL_W'(4);
        sel_valid_nxt = 1'b1;
      end
      FETCH: begin
        sel_nxt       = SEL_W'(3);
        sel_valid_nxt = 1'b1;
        done_nxt      = 1'b1;
      end
      FIN: begin
        done_nxt        = 1'b1;
        err_illegal_nxt = !to_nxt;
        timeout_err_nxt = to_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= '0;
      sel_valid   <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sel         <= sel_nxt;
      sel_valid   <= sel_valid_nxt;
      done        <= done_nxt;
      err_illegal <= err_illegal_nxt;
      timeout_err <= timeout_err_nxt;
      busy        <= busy_nxt;
      cmd_ready   <= cmd_ready_nxt;
    end
  end

  // Latched opcode is data only; it is qualified by state.
  always_ff @(posedge clk) begin
    op <= op_nxt;
  end

endmodule
